// File: rtl/buzz_seq.sv
// Buzzer sequencer: square-wave tone with programmable period, played as N timed beeps
// (or endlessly), plus a legacy continuous-tone mode while idle.
module buzz_seq #(
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned TIME_W   = 16,
  parameter int unsigned REP_W    = 8,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              en_cont,
  input  logic [DIV_W-1:0]  tone_div,
  input  logic [TIME_W-1:0] on_ms,
  input  logic [TIME_W-1:0] off_ms,
  input  logic [REP_W-1:0]  repeats,
  output logic              buz,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW    = DIV_W + 1;

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e            state;
  logic [DIV_W-1:0]  div_l, phase;
  logic [TIME_W-1:0] on_l, off_l, tick_cnt;
  logic [REP_W-1:0]  rep_l, beep_cnt;
  logic [PRE_W-1:0]  presc;

  logic              tick, on_last, off_last, last_beep;
  logic              seq_tone, idle_tone, seq_wrap, idle_wrap;
  logic [HW-1:0]     seq_half, idle_half;
  logic [TIME_W-1:0] on_end;
  logic [REP_W-1:0]  beep_next;

  assign busy = (state != StIdle);

  always_comb begin
    tick      = (presc == PRE_W'(TICK_DIV - 1));
    // Extra bit so all-ones tone_div does not overflow the +1.
    seq_half  = ({1'b0, div_l} + HW'(1)) >> 1;
    idle_half = ({1'b0, tone_div} + HW'(1)) >> 1;
    seq_tone  = (div_l != '0) && ({1'b0, phase} >= seq_half);
    idle_tone = (tone_div != '0) && ({1'b0, phase} >= idle_half);
    seq_wrap  = (phase >= div_l);
    idle_wrap = (phase >= tone_div);
    // on_ms = 0 still gives a one-tick beep.
    on_end    = (on_l == '0) ? '0 : on_l - TIME_W'(1);
    on_last   = tick && (tick_cnt == on_end);
    off_last  = tick && (tick_cnt == off_l - TIME_W'(1));
    beep_next = beep_cnt + REP_W'(1);
    last_beep = (rep_l != '0) && (beep_next == rep_l);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      buz      <= 1'b0;
      done     <= 1'b0;
      div_l    <= '0;
      on_l     <= '0;
      off_l    <= '0;
      rep_l    <= '0;
      phase    <= '0;
      presc    <= '0;
      tick_cnt <= '0;
      beep_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start && !stop) begin
            div_l    <= tone_div;
            on_l     <= on_ms;
            off_l    <= off_ms;
            rep_l    <= repeats;
            state    <= StOn;
            phase    <= '0;
            presc    <= '0;
            tick_cnt <= '0;
            beep_cnt <= '0;
            buz      <= 1'b0;
          end else if (en_cont) begin
            buz   <= idle_tone;
            phase <= idle_wrap ? '0 : phase + DIV_W'(1);
          end else begin
            buz   <= 1'b0;
            phase <= '0;
          end
        end
        StOn: begin
          if (stop) begin
            state <= StIdle;
            buz   <= 1'b0;
            phase <= '0;
          end else if (on_last) begin
            beep_cnt <= beep_next;
            presc    <= '0;
            tick_cnt <= '0;
            phase    <= '0;
            buz      <= 1'b0;
            if (last_beep) begin
              state <= StIdle;
              done  <= 1'b1;
            end else if (off_l == '0) begin
              state <= StOn;
            end else begin
              state <= StOff;
            end
          end else begin
            buz      <= seq_tone;
            phase    <= seq_wrap ? '0 : phase + DIV_W'(1);
            presc    <= tick ? '0 : presc + PRE_W'(1);
            tick_cnt <= tick ? tick_cnt + TIME_W'(1) : tick_cnt;
          end
        end
        StOff: begin
          buz <= 1'b0;
          if (stop) begin
            state <= StIdle;
            phase <= '0;
          end else if (off_last) begin
            state    <= StOn;
            phase    <= '0;
            presc    <= '0;
            tick_cnt <= '0;
          end else begin
            presc    <= tick ? '0 : presc + PRE_W'(1);
            tick_cnt <= tick ? tick_cnt + TIME_W'(1) : tick_cnt;
          end
        end
        default: begin
          state <= StIdle;
          buz   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/buzz_seq.md
Name: buzz_seq

Overview:
- Parametrised successor to the fixed 1.25 kHz buzzer driver.
- Generates a square-wave tone with a runtime-programmable period.
- Plays beep sequences: N beeps of programmable on/off length in ms ticks, or endless until stopped.
- Keeps a legacy continuous-tone enable. Sits between key/alarm control logic and the buzzer pin.

Parameters:
DIV_W, 16, width of tone_div (tone period = tone_div+1 clk cycles)
TIME_W, 16, width of on_ms/off_ms
REP_W, 8, width of repeat
TICK_DIV, 50000, clk cycles per time tick (1 ms at 50 MHz; bench overrides to 10)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; begins a sequence when IDLE
stop  in  1  single-cycle abort; returns to IDLE
en_cont  in  1  level; continuous tone while IDLE
tone_div  in  DIV_W  tone period minus one, in clk cycles
on_ms  in  TIME_W  beep length in ticks
off_ms  in  TIME_W  gap length in ticks
repeat  in  REP_W  number of beeps; 0 = endless
buz  out  1  registered buzzer drive
busy  out  1  high in ON/OFF states
done  out  1  one-cycle pulse at natural end of a finite sequence

Behaviour:
- Reset: buz=0, busy=0, done=0, state=IDLE, all counters and latched configuration 0.
- FSM states: IDLE, ON, OFF. busy = (state != IDLE), decoded from the state register.
- Starting a sequence:
  - In IDLE, start=1 (and stop=0) latches tone_div, on_ms, off_ms, repeat. The same edge enters ON and clears the phase, tick prescaler and tick counters.
  - Input changes during a sequence have no effect; start is ignored while busy.
- Tone generation:
  - phase counts 0..div_l (latched tone_div) and wraps to 0.
  - half = (div_l+1)>>1, computed at DIV_W+1 bits so all-ones tone_div does not overflow.
  - Registered: buz <= (phase >= half) while ON. buz lags phase by one clk.
  - div_l=0: buz held 0 (silent beep, timing unaffected). div_l=1: buz toggles every clk.
- Timing:
  - Prescaler counts 0..TICK_DIV-1. One tick at terminal count; the prescaler restarts on every state entry.
  - ON lasts exactly max(on_ms,1)*TICK_DIV cycles. OFF lasts off_ms*TICK_DIV cycles.
- Transitions at end of ON:
  - Finite sequence, last beep (beep count reached repeat): go to IDLE and pulse done=1 on that same edge.
  - Else if off_ms=0: re-enter ON directly; phase restarts at 0.
  - Else: go to OFF.
- OFF end: go to ON, phase reset. buz registers 0 throughout OFF.
- Beep counter: REP_W bits, increments at each ON end. With repeat=0 it is not compared (endless).
- stop:
  - Any state → IDLE on the next edge. buz=0 on that same edge, no done pulse.
  - stop has priority over a same-cycle start.
  - stop in IDLE has no effect.
- en_cont:
  - In IDLE with en_cont=1, phase free-runs on the live tone_div input and buz follows the same rule (legacy mode).
  - busy stays 0 in this mode. A start in IDLE overrides it.
  - Back in IDLE, the continuous tone resumes with phase restarting at 0.
- Reset mid-operation: immediate asynchronous return to the reset values.
- done is high for exactly 1 cycle per completed finite sequence.

Test Plan:
- TICK_DIV=10, tone_div=3, on_ms=2, off_ms=1, repeat=2, start pulse →
  - busy high 50 cycles;
  - buz pattern 0,0,1,1 repeated for 20 cycles, then 10 cycles low, then 20 cycles of pattern;
  - done pulse on the cycle busy falls.
- en_cont=1, idle, tone_div=39999, TICK_DIV default → buz 20000 cycles low / 20000 high, period 40000 (1.25 kHz); busy=0, done never asserted.
- repeat=0, on_ms=1, off_ms=1 → beeps continue past 300 beeps; stop pulse → next edge state IDLE, buz=0, busy=0, no done.
- off_ms=0, repeat=3, on_ms=1, tone_div=4 → busy continuous 30 cycles; phase restarts each beep (buz low 3 clks at each beep start); one done pulse.
- Boundaries:
  - tone_div=0 → buz stays 0 while busy times normally;
  - on_ms=0 → beep lasts 1 tick;
  - start and stop in the same cycle → stays IDLE.
- rst asserted mid-ON, asynchronous to clk → buz, busy, done 0 immediately; after release a new start behaves as the first scenario.
